// File: rtl/uop_buffer_pkg.sv
// Shared microcode definitions: bundle format, default store depth and the
// fill state encoding used by the buffer and by debug displays.
package uop_buffer_pkg;

  localparam int UOP_BUF_SIZE = 16;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  dst;
    logic [15:0] imm;
  } instruction_bundle;

  typedef enum logic {
    UB_IDLE = 1'b0,
    UB_FILL = 1'b1
  } ub_fill_state_e;

endpackage

// File: rtl/uop_fill_ctrl.sv
// Fill controller: accepts a fill request, walks a wrapping write pointer
// over the requested number of beats and pulses fill_done when finished.
module uop_fill_ctrl
  import uop_buffer_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [AW:0]   fill_count,
  input  logic          wr_valid,
  input  logic          invalidate,
  output logic          wr_ready,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx
);

  ub_fill_state_e state_q, state_d;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    remaining_q;
  logic [AW:0]    count_sat;
  logic           start_ok;
  logic           last_beat;

  // Clamp oversize requests to one full pass over the store.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_sat = fill_count;
    if (fill_count > (AW+1)'(SIZE)) count_sat = (AW+1)'(SIZE);
  end

  assign start_ok  = (state_q == UB_IDLE) && fill_start;
  assign last_beat = wr_en && (remaining_q == (AW+1)'(1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state_q <= UB_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; invalidate aborts a fill but still lets a new one start from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UB_IDLE: if (start_ok && (count_sat != '0)) state_d = UB_FILL;
      UB_FILL: if (invalidate || last_beat)       state_d = UB_IDLE;
      default:                                    state_d = UB_IDLE;
    endcase
  end

  // Outputs decoded from state; wr_ready never looks at wr_valid.
  always_comb begin
    wr_ready  = (state_q == UB_FILL);
    fill_busy = (state_q == UB_FILL);
    wr_en     = (state_q == UB_FILL) && wr_valid && !invalidate;
    wr_idx    = wr_ptr_q;
  end

  // Pointer, beat counter and the one-cycle completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      remaining_q <= '0;
      fill_done   <= 1'b0;
    end else begin
      fill_done <= (start_ok && (count_sat == '0)) || last_beat;
      if (start_ok) begin
        wr_ptr_q    <= fill_base;
        remaining_q <= count_sat;
      end else if (wr_en) begin
        wr_ptr_q    <= wr_ptr_q + AW'(1);
        remaining_q <= remaining_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uop_buffer.sv
// Microcode bundle store: loader-filled array with per-entry valid bits and
// a zero-latency combinational read port for the fetch stage.
module uop_buffer
  import uop_buffer_pkg::*;
#(
  parameter int UOP_BUF_SIZE = uop_buffer_pkg::UOP_BUF_SIZE,
  parameter int AW           = $clog2(UOP_BUF_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_start,
  input  logic [AW-1:0]     fill_base,
  input  logic [AW:0]       fill_count,
  input  logic              wr_valid,
  input  instruction_bundle wr_bundle,
  output logic              wr_ready,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              invalidate,
  input  logic [AW-1:0]     uop_addr,
  output instruction_bundle uop,
  output logic              uop_hit,
  output logic [AW:0]       valid_count
);

  instruction_bundle       mem [UOP_BUF_SIZE];
  logic [UOP_BUF_SIZE-1:0] valid;
  logic                    wr_en;
  logic [AW-1:0]           wr_idx;

  uop_fill_ctrl #(
    .SIZE (UOP_BUF_SIZE),
    .AW   (AW)
  ) u_fill_ctrl (
    .clk        (clk),
    .reset      (reset),
    .fill_start (fill_start),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .wr_valid   (wr_valid),
    .invalidate (invalidate),
    .wr_ready   (wr_ready),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx)
  );

  // Bundle storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; the valid bits alone say which entries are meaningful.
    if (wr_en) mem[wr_idx] <= wr_bundle;
  end

  // Valid bits and population count; invalidate beats any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      valid_count <= '0;
    end else if (invalidate) begin
      valid       <= '0;
      valid_count <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      if (!valid[wr_idx]) valid_count <= valid_count + (AW+1)'(1);
    end
  end

  // Combinational read port; a write shows up only after its clock edge.
  always_comb begin
    uop     = mem[uop_addr];
    uop_hit = valid[uop_addr];
  end

endmodule

// File: tb/tb_uop_buffer.sv
// Directed testbench for uop_buffer with UOP_BUF_SIZE = 16.
module tb_uop_buffer;
  import uop_buffer_pkg::*;

  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              fill_start;
  logic [AW-1:0]     fill_base;
  logic [AW:0]       fill_count;
  logic              wr_valid;
  instruction_bundle wr_bundle;
  logic              wr_ready;
  logic              fill_busy;
  logic              fill_done;
  logic              invalidate;
  logic [AW-1:0]     uop_addr;
  instruction_bundle uop;
  logic              uop_hit;
  logic [AW:0]       valid_count;

  int tests_run    = 0;
  int tests_failed = 0;

  uop_buffer #(.UOP_BUF_SIZE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fill_start  (fill_start),
    .fill_base   (fill_base),
    .fill_count  (fill_count),
    .wr_valid    (wr_valid),
    .wr_bundle   (wr_bundle),
    .wr_ready    (wr_ready),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .invalidate  (invalidate),
    .uop_addr    (uop_addr),
    .uop         (uop),
    .uop_hit     (uop_hit),
    .valid_count (valid_count)
  );

  always #5 clk = ~clk;

  function automatic instruction_bundle mk(input int k);
    instruction_bundle b;
    b.opcode = 8'(8'h40 + k);
    b.dst    = 8'(k);
    b.imm    = 16'(16'hBE00 + k);
    return b;
  endfunction

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input int base, input int count);
    fill_start = 1'b1;
    fill_base  = AW'(base);
    fill_count = (AW+1)'(count);
    step();
    fill_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fill_start = 1'b0; fill_base = '0; fill_count = '0;
    wr_valid = 1'b0; wr_bundle = '0; invalidate = 1'b0; uop_addr = '0;
    #3;
    for (int a = 0; a < 16; a += 5) begin
      uop_addr = AW'(a);
      #1;
      tests_run++;
      if (uop_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit[%0d]: got %b want 0", a, uop_hit); end
    end
    tests_run++;
    if (valid_count !== '0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", valid_count); end
    tests_run++;
    if (wr_ready !== 1'b0 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: ready/busy/done got %b%b%b want 000", wr_ready, fill_busy, fill_done);
    end
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_fill();
    int pulses = 0;
    start_fill(3, 4);
    tests_run++;
    if (fill_busy !== 1'b1 || wr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL basic_start: busy/ready got %b%b want 11", fill_busy, wr_ready);
    end
    wr_valid = 1'b1;
    uop_addr = AW'(3);
    for (int k = 0; k < 4; k++) begin
      wr_bundle = mk(k);
      if (k == 0) begin
        #1;
        tests_run++;
        if (uop_hit !== 1'b0) begin tests_failed++; $display("FAIL basic_no_bypass: hit got %b want 0", uop_hit); end
      end
      step();
      if (fill_done === 1'b1) pulses++;
    end
    wr_valid = 1'b0;
    tests_run++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done: done/busy got %b%b want 10", fill_done, fill_busy);
    end
    tests_run++;
    if (valid_count !== 5'd4) begin tests_failed++; $display("FAIL basic_count: got %0d want 4", valid_count); end
    uop_addr = AW'(5);
    #1;
    tests_run++;
    if (uop !== mk(2) || uop_hit !== 1'b1) begin
      tests_failed++; $display("FAIL basic_read5: got %h hit %b want %h hit 1", uop, uop_hit, mk(2));
    end
    uop_addr = AW'(7);
    #1;
    tests_run++;
    if (uop_hit !== 1'b0) begin tests_failed++; $display("FAIL basic_hit7: got %b want 0", uop_hit); end
    step();
    if (fill_done === 1'b1) pulses++;
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL basic_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_wrap();
    int beats = 0;
    int cyc   = 0;
    int early = 0;
    instruction_bundle exp_b [4];
    int                exp_a [4];
    exp_a[0] = 14; exp_a[1] = 15; exp_a[2] = 0; exp_a[3] = 1;
    for (int i = 0; i < 4; i++) exp_b[i] = mk(20 + i);
    start_fill(14, 4);
    while (beats < 4 && cyc < 20) begin
      wr_valid  = (cyc % 2 == 0);
      wr_bundle = mk(20 + beats);
      #1;
      tests_run++;
      if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL wrap_ready[%0d]: got %b want 1", cyc, wr_ready); end
      step();
      if (wr_valid) beats++;
      if (beats < 4 && fill_done === 1'b1) early++;
      cyc++;
    end
    wr_valid = 1'b0;
    tests_run++;
    if (beats !== 4 || fill_done !== 1'b1 || early !== 0) begin
      tests_failed++; $display("FAIL wrap_done: beats %0d done %b early %0d want 4 1 0", beats, fill_done, early);
    end
    for (int i = 0; i < 4; i++) begin
      uop_addr = AW'(exp_a[i]);
      #1;
      tests_run++;
      if (uop !== exp_b[i] || uop_hit !== 1'b1) begin
        tests_failed++; $display("FAIL wrap_entry[%0d]: got %h hit %b want %h hit 1", exp_a[i], uop, uop_hit, exp_b[i]);
      end
    end
    tests_run++;
    if (valid_count !== 5'd8) begin tests_failed++; $display("FAIL wrap_count: got %0d want 8", valid_count); end
    step();
  endtask

  task automatic test_saturate();
    int beats = 0;
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    tests_run++;
    if (valid_count !== '0) begin tests_failed++; $display("FAIL sat_clear: got %0d want 0", valid_count); end
    start_fill(0, 20);
    wr_valid = 1'b1;
    while (fill_busy === 1'b1 && beats < 40) begin
      wr_bundle = mk(100 + beats);
      step();
      beats++;
    end
    wr_valid = 1'b0;
    tests_run++;
    if (beats !== 16) begin tests_failed++; $display("FAIL sat_beats: got %0d want 16", beats); end
    tests_run++;
    if (valid_count !== 5'd16) begin tests_failed++; $display("FAIL sat_count: got %0d want 16", valid_count); end
    uop_addr = AW'(15);
    #1;
    tests_run++;
    if (uop !== mk(115)) begin tests_failed++; $display("FAIL sat_entry15: got %h want %h", uop, mk(115)); end
    start_fill(5, 2);
    wr_valid = 1'b1;
    wr_bundle = mk(200); step();
    wr_bundle = mk(201); step();
    wr_valid = 1'b0;
    uop_addr = AW'(6);
    #1;
    tests_run++;
    if (valid_count !== 5'd16 || uop !== mk(201)) begin
      tests_failed++; $display("FAIL sat_refill: count %0d data %h want 16 %h", valid_count, uop, mk(201));
    end
    step();
  endtask

  task automatic test_invalidate();
    start_fill(0, 5);
    wr_valid = 1'b1;
    wr_bundle = mk(50); step();
    wr_bundle = mk(51); invalidate = 1'b1; step();
    invalidate = 1'b0; wr_valid = 1'b0;
    uop_addr = AW'(1);
    #1;
    tests_run++;
    if (uop !== mk(101) || uop_hit !== 1'b0) begin
      tests_failed++; $display("FAIL inv_dropped: got %h hit %b want %h hit 0", uop, uop_hit, mk(101));
    end
    tests_run++;
    if (fill_busy !== 1'b0 || fill_done !== 1'b0 || valid_count !== '0) begin
      tests_failed++; $display("FAIL inv_state: busy %b done %b count %0d want 0 0 0", fill_busy, fill_done, valid_count);
    end
    step();
    tests_run++;
    if (fill_done !== 1'b0) begin tests_failed++; $display("FAIL inv_no_done: got %b want 0", fill_done); end
    // Populate one entry, then invalidate and start together from IDLE.
    start_fill(9, 1);
    wr_valid = 1'b1; wr_bundle = mk(55); step();
    wr_valid = 1'b0;
    step();
    invalidate = 1'b1;
    start_fill(10, 2);
    invalidate = 1'b0;
    uop_addr = AW'(9);
    #1;
    tests_run++;
    if (fill_busy !== 1'b1 || valid_count !== '0 || uop_hit !== 1'b0) begin
      tests_failed++; $display("FAIL inv_start: busy %b count %0d hit %b want 1 0 0", fill_busy, valid_count, uop_hit);
    end
    wr_valid = 1'b1;
    wr_bundle = mk(60); step();
    wr_bundle = mk(61); step();
    wr_valid = 1'b0;
    uop_addr = AW'(11);
    #1;
    tests_run++;
    if (fill_done !== 1'b1 || valid_count !== 5'd2 || uop !== mk(61)) begin
      tests_failed++; $display("FAIL inv_refill: done %b count %0d data %h want 1 2 %h", fill_done, valid_count, uop, mk(61));
    end
    step();
  endtask

  task automatic test_zero_count();
    start_fill(4, 0);
    tests_run++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_done: done/busy got %b%b want 10", fill_done, fill_busy);
    end
    step();
    tests_run++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      tests_failed++; $display("FAIL zero_after: done/busy got %b%b want 00", fill_done, fill_busy);
    end
  endtask

  task automatic test_reset_midfill();
    start_fill(2, 4);
    wr_valid = 1'b1; wr_bundle = mk(70); step();
    uop_addr = AW'(2);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (fill_busy !== 1'b0 || wr_ready !== 1'b0 || valid_count !== '0 || uop_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: busy %b ready %b count %0d hit %b want 0 0 0 0", fill_busy, wr_ready, valid_count, uop_hit);
    end
    wr_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_after: done/busy got %b%b want 00", fill_done, fill_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_wrap();
    test_saturate();
    test_invalidate();
    test_zero_count();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within limit");
    $fatal(1, "timeout");
  end

endmodule
